cpu5_mcalu: RTL and testbench

- Multi-cycle execute unit; the consumer of the 3-bit alucontrol code that the ALU decoder produces.
- Sits in the EX stage beside the single-cycle ALU.
- Takes operands plus alucontrol through a valid/ready handshake and returns one registered result per accepted op.
- Iterative shifts and multiply stall the pipeline through in_ready/out_valid.

---
 rtl/cpu5_mcalu.sv | 197 +++++++++++++++++++
 tb/tb_cpu5_mcalu.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu5_mcalu.sv
// Multi-cycle EX-stage unit: bitwise/add/sub/slt, iterative shifts and shift-add multiply.
// Optional macro CPU5_MCALU_EARLY_EXIT_EN: MUL stops once the remaining multiplier is zero.
module cpu5_mcalu #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      alucontrol,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned CNTW = SHW + 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   work_q, work_d;
    logic [XLEN-1:0]   mplr_q, mplr_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic [XLEN-1:0]   single_res_c;
    logic [SHW-1:0]    shamt_c;
    logic [XLEN-1:0]   step_work_c;
    logic [XLEN-1:0]   step_mplr_c;
    logic [XLEN-1:0]   step_acc_c;
    logic              last_iter_c;

    assign shamt_c = src_b[SHW-1:0];

    // One-cycle operations evaluated straight from the input operands.
    always_comb begin
        single_res_c = '0;
        case (alucontrol)
            OP_AND:  single_res_c = src_a & src_b;
            OP_OR:   single_res_c = src_a | src_b;
            OP_ADD:  single_res_c = src_a + src_b;
            OP_SUB:  single_res_c = src_a - src_b;
            OP_SLT:  single_res_c = XLEN'($signed(src_a) < $signed(src_b));
            default: single_res_c = '0;
        endcase
    end

    // One iteration of the running op; the counter holds iterations still to do.
    always_comb begin
        step_work_c = work_q;
        step_mplr_c = mplr_q;
        step_acc_c  = acc_q;
        last_iter_c = (cnt_q == CNTW'(1));
        case (op_q)
            OP_MUL: begin
                step_acc_c  = acc_q + (mplr_q[0] ? work_q : '0);
                step_work_c = work_q << 1;
                step_mplr_c = mplr_q >> 1;
`ifdef CPU5_MCALU_EARLY_EXIT_EN
                if (step_mplr_c == '0) begin
                    last_iter_c = 1'b1;
                end
`endif
            end
            OP_SLL:  step_work_c = work_q << 1;
            default: step_work_c = work_q >> 1;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        mplr_d   = mplr_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    op_d = alucontrol;
                    case (alucontrol)
                        OP_SLL, OP_SRL: begin
                            if (shamt_c == '0) begin
                                result_d = src_a;
                                state_d  = S_DONE;
                            end else begin
                                work_d  = src_a;
                                cnt_d   = CNTW'(shamt_c);
                                state_d = S_RUN;
                            end
                        end
                        OP_MUL: begin
                            work_d  = src_a;
                            mplr_d  = src_b;
                            acc_d   = '0;
                            cnt_d   = CNTW'(XLEN);
                            state_d = S_RUN;
`ifdef CPU5_MCALU_EARLY_EXIT_EN
                            if (src_b == '0) begin
                                result_d = '0;
                                state_d  = S_DONE;
                            end
`endif
                        end
                        default: begin
                            result_d = single_res_c;
                            state_d  = S_DONE;
                        end
                    endcase
                end
            end
            S_RUN: begin
                work_d = step_work_c;
                mplr_d = step_mplr_c;
                acc_d  = step_acc_c;
                cnt_d  = cnt_q - CNTW'(1);
                if (last_iter_c) begin
                    result_d = (op_q == OP_MUL) ? step_acc_c : step_work_c;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a pending handshake.
        if (flush) begin
            state_d = S_IDLE;
        end

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d == S_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            work_q      <= '0;
            mplr_q      <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            work_q      <= work_d;
            mplr_q      <= mplr_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;

endmodule

// File: tb/tb_cpu5_mcalu.sv
// Self-checking bench for cpu5_mcalu: cycle-level reference model plus directed and random ops.
module tb_cpu5_mcalu;

    localparam int XLEN = 32;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

`ifdef CPU5_MCALU_EARLY_EXIT_EN
    localparam int LAT_MUL_FFFF = 18;
    localparam int LAT_MUL_2    = 3;
    localparam int LAT_MUL_3    = 3;
    localparam int LAT_MUL_0    = 1;
`else
    localparam int LAT_MUL_FFFF = 33;
    localparam int LAT_MUL_2    = 33;
    localparam int LAT_MUL_3    = 33;
    localparam int LAT_MUL_0    = 33;
`endif

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      alucontrol;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 0;

    int              m_left;
    bit              m_valid;
    logic [XLEN-1:0] m_res;

    cpu5_mcalu dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alucontrol (alucontrol),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_res(input logic [2:0] op, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLL:  r = a << b[4:0];
            OP_SRL:  r = a >> b[4:0];
            default: r = a * b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [XLEN-1:0] b);
        int n;
        if (op == OP_SLL || op == OP_SRL) return (b[4:0] == 5'd0) ? 1 : int'(b[4:0]) + 1;
        if (op != OP_MUL) return 1;
`ifdef CPU5_MCALU_EARLY_EXIT_EN
        n = 0;
        for (int i = 0; i < XLEN; i++) if (b[i]) n = i + 1;
        return (n == 0) ? 1 : n + 1;
`else
        n = XLEN;
        return n + 1;
`endif
    endfunction

    // Reference: an accepted op becomes visible ref_lat cycles later and stays until taken.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left  = 0;
            m_valid = 0;
            m_res   = '0;
        end else if (flush) begin
            m_left  = 0;
            m_valid = 0;
        end else if (m_valid) begin
            if (out_ready) m_valid = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_valid = 1;
        end else if (in_valid) begin
            m_res  = ref_res(alucontrol, src_a, src_b);
            m_left = ref_lat(alucontrol, src_b) - 1;
            if (m_left == 0) m_valid = 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_in_ready", 32'(in_ready), 32'(!m_valid && m_left == 0));
            chk("cmp_out_valid", 32'(out_valid), 32'(m_valid));
            chk("cmp_busy", 32'(busy), 32'(m_left > 0));
            if (m_valid) chk("cmp_result", result, m_res);
        end
    end

    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                          input int hold, input int exp_busy);
        int lat;
        int nb;
        @(posedge clk); #1;
        in_valid = 1'b1; alucontrol = op; src_a = a; src_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0; alucontrol = 3'($urandom); src_a = $urandom; src_b = $urandom;
        lat = 1;
        nb  = 0;
        while (!out_valid && lat < 200) begin
            if (busy) nb++;
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_res"}, result, exp_res);
        if (exp_busy >= 0) chk({nm, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; alucontrol = 3'($urandom); src_a = $urandom; src_b = $urandom;
            @(posedge clk); #1;
            chk({nm, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            chk({nm, "_hold_result"}, result, exp_res);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, "_idle_after"}, 32'(in_ready), 32'd1);
    endtask

    task automatic rand_op();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int t;
        op = 3'($urandom);
        a  = $urandom;
        b  = $urandom;
        if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
        @(posedge clk); #1;
        in_valid = 1'b1; alucontrol = op; src_a = a; src_b = b;
        flush = ($urandom_range(0, 15) == 0);
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; src_a = $urandom; src_b = $urandom;
        alucontrol = 3'($urandom);
        if ($urandom_range(0, 7) == 0) begin
            repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
        end
        t = 0;
        while (!out_valid && !in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("rand_wait_bound", 32'(t < 100), 32'd1);
        if (out_valid) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    initial begin
        int seen;
        reset = 1'b1; in_valid = 1'b1; alucontrol = OP_ADD; src_a = 32'd5; src_b = 32'd6;
        flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", result, 32'd0);
        chk_en = 1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;

        run_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1, 0, -1);
        run_op("sub", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 0, -1);
        run_op("slt_neg", OP_SLT, 32'h8000_0000, 32'd1, 32'd1, 1, 0, -1);
        run_op("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1, 0, -1);
        run_op("or", OP_OR, 32'hF000_0001, 32'h0000_0010, 32'hF000_0011, 1, 0, -1);
        run_op("sll31", OP_SLL, 32'h0000_0001, 32'd31, 32'h8000_0000, 32, 0, 31);
        run_op("srl0", OP_SRL, 32'h8000_0000, 32'h0000_0100, 32'h8000_0000, 1, 0, 0);
        run_op("srl4", OP_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 5, 0, 4);
        run_op("mul_ffff", OP_MUL, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, LAT_MUL_FFFF, 0, -1);
        run_op("mul_trunc", OP_MUL, 32'h8000_0000, 32'd2, 32'h0000_0000, LAT_MUL_2, 0, -1);
        run_op("mul_7x3", OP_MUL, 32'd7, 32'd3, 32'd21, LAT_MUL_3, 0, -1);
        run_op("mul_b0", OP_MUL, 32'h1234_5678, 32'd0, 32'd0, LAT_MUL_0, 0, -1);
        run_op("backpressure", OP_ADD, 32'd100, 32'd23, 32'd123, 1, 10, -1);

        // Abort a multiply in its fifth RUN cycle.
        @(posedge clk); #1;
        in_valid = 1'b1; alucontrol = OP_MUL; src_a = 32'd123; src_b = 32'd456;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("flush_pre_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_busy", 32'(busy), 32'd0);
        seen = 0;
        repeat (40) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("flush_no_valid", 32'(seen), 32'd0);
        run_op("flush_add", OP_ADD, 32'd1, 32'd1, 32'd2, 1, 0, -1);

        // Flush together with a request in IDLE must not accept it.
        @(posedge clk); #1;
        in_valid = 1'b1; flush = 1'b1; alucontrol = OP_ADD; src_a = 32'd9; src_b = 32'd9;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        seen = 0;
        repeat (3) begin
            if (out_valid || busy || !in_ready) seen++;
            @(posedge clk); #1;
        end
        chk("flush_idle_no_accept", 32'(seen), 32'd0);

        // Asynchronous reset between edges during a long shift.
        @(posedge clk); #1;
        in_valid = 1'b1; alucontrol = OP_SRL; src_a = 32'hDEAD_BEEF; src_b = 32'd20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2;
        reset = 1'b1;
        #1;
        chk("areset_in_ready", 32'(in_ready), 32'd1);
        chk("areset_busy", 32'(busy), 32'd0);
        chk("areset_out_valid", 32'(out_valid), 32'd0);
        chk("areset_result", result, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        repeat (30) begin
            if (out_valid || busy || result != 32'd0) seen++;
            @(posedge clk); #1;
        end
        chk("areset_no_stale", 32'(seen), 32'd0);

        for (int k = 0; k < 200; k++) rand_op();

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
